// File: rtl/rvfi_pkg.sv
// ============================================================================
// Module  : rvfi_pkg
// Purpose : RVFI commit record type and the serialized trace record built on
//           it by rvfi_trace_arbiter.
// Types   : rvfi_instr_t     - one commit-port record
//           rvfi_trace_rec_t - {instr, seq, port} as emitted on the trace
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rvfi_pkg;

   localparam int unsigned c_XLEN = 32;

   typedef struct packed {
      logic              valid;
      logic [63:0]       order;
      logic [31:0]       insn;
      logic              trap;
      logic              halt;
      logic              intr;
      logic [1:0]        mode;
      logic [4:0]        rs1_addr;
      logic [4:0]        rs2_addr;
      logic [4:0]        rd_addr;
      logic [c_XLEN-1:0] rd_wdata;
      logic [c_XLEN-1:0] pc_rdata;
      logic [c_XLEN-1:0] pc_wdata;
      logic [c_XLEN-1:0] mem_addr;
   } rvfi_instr_t;

   typedef struct packed {
      rvfi_instr_t instr;
      logic [31:0] seq;
      logic [7:0]  port;
   } rvfi_trace_rec_t;

endpackage

`default_nettype wire

// File: rtl/rvfi_commit_packer.sv
// ============================================================================
// Module  : rvfi_commit_packer
// Purpose : Purely combinational compaction of one cycle's commit records.
//           Eligible ports (valid or trap) are packed into the low slots in
//           ascending port order; each slot carries its source port index.
// Ports   : i_rvfi   - per-port commit records
//           o_n      - number of eligible records (0..NR_COMMIT_PORTS)
//           o_packed - compacted records, slots >= o_n are zero
//           o_port   - source port of each packed slot
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_commit_packer
   import rvfi_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2
) (
   input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]       i_rvfi,
   output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]    o_n,
   output rvfi_instr_t [NR_COMMIT_PORTS-1:0]       o_packed,
   output logic [NR_COMMIT_PORTS-1:0][7:0]         o_port
);

   localparam int unsigned c_N_W = $clog2(NR_COMMIT_PORTS + 1);

   always_comb begin
      int w_cnt;
      w_cnt    = 0;
      o_packed = '0;
      o_port   = '0;
      for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
         if (i_rvfi[p].valid || i_rvfi[p].trap) begin
            // Slot selection by comparison keeps the slot index a constant,
            // so no variable-width array select is needed.
            for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
               if (k == w_cnt) begin
                  o_packed[k] = i_rvfi[p];
                  o_port[k]   = 8'(p);
               end
            end
            w_cnt = w_cnt + 1;
         end
      end
      o_n = c_N_W'(w_cnt);
   end

endmodule

`default_nettype wire

// File: rtl/rvfi_trace_arbiter.sv
// ============================================================================
// Module  : rvfi_trace_arbiter
// Purpose : Serializes all RVFI commit ports into one ordered, back-pressured
//           trace stream through a FIFO. Each record gets a global sequence
//           number; a cycle whose records do not all fit is dropped whole and
//           counted.
// Ports   : clk_i, rst_i      - clock, synchronous active-high reset
//           rvfi_i            - per-port commit records (port 0 oldest)
//           trace_valid_o/_o  - head record valid / head record
//           trace_ready_i     - consumer accepts head record
//           level_o           - FIFO occupancy
//           overflow_o        - sticky, set on first dropped cycle
//           drop_cnt_o        - saturating count of dropped records
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_trace_arbiter
   import rvfi_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned DEPTH           = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_i,
   output logic                               trace_valid_o,
   input  logic                               trace_ready_i,
   output rvfi_trace_rec_t                    trace_o,
   output logic [$clog2(DEPTH):0]             level_o,
   output logic                               overflow_o,
   output logic [31:0]                        drop_cnt_o
);

   localparam int unsigned c_PTR_W = $clog2(DEPTH);
   localparam int unsigned c_LVL_W = c_PTR_W + 1;
   localparam int unsigned c_N_W   = $clog2(NR_COMMIT_PORTS + 1);

   rvfi_trace_rec_t                   r_mem [DEPTH];
   logic [c_PTR_W-1:0]                r_wr_ptr;
   logic [c_PTR_W-1:0]                r_rd_ptr;
   logic [c_LVL_W-1:0]                r_level;
   logic [31:0]                       r_seq;
   logic [31:0]                       r_drop_cnt;
   logic                              r_overflow;

   logic [c_N_W-1:0]                  w_n;
   rvfi_instr_t [NR_COMMIT_PORTS-1:0] w_packed;
   logic [NR_COMMIT_PORTS-1:0][7:0]   w_port;
   logic                              w_pop;
   logic                              w_accept;
   logic [c_LVL_W:0]                  w_free;
   logic [32:0]                       w_drop_sum;

   rvfi_commit_packer #(
      .NR_COMMIT_PORTS (NR_COMMIT_PORTS)
   ) u_packer (
      .i_rvfi   (rvfi_i),
      .o_n      (w_n),
      .o_packed (w_packed),
      .o_port   (w_port)
   );

   assign w_pop      = trace_valid_o && trace_ready_i;
   // A same-cycle pop frees one slot for this cycle's push.
   assign w_free     = (c_LVL_W+1)'(DEPTH) - {1'b0, r_level} + (c_LVL_W+1)'(w_pop);
   assign w_accept   = ((c_LVL_W+1)'(w_n) <= w_free);
   assign w_drop_sum = {1'b0, r_drop_cnt} + 33'(w_n);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_seq      <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_n);
            r_seq    <= r_seq + 32'(w_n);
         end else begin
            // Whole cycle rejected: sequence numbers are not consumed.
            r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
            r_overflow <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_level <= r_level + (w_accept ? c_LVL_W'(w_n) : '0) - c_LVL_W'(w_pop);
      end
   end

   // Storage is not reset; occupancy is tracked solely by r_level.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_accept) begin
         for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            if (k < int'(w_n)) begin
               r_mem[r_wr_ptr + c_PTR_W'(k)] <= '{instr: w_packed[k],
                                                  seq:   r_seq + 32'(k),
                                                  port:  w_port[k]};
            end
         end
      end
   end

   assign trace_valid_o = (r_level != '0);
   assign trace_o       = r_mem[r_rd_ptr];
   assign level_o       = r_level;
   assign overflow_o    = r_overflow;
   assign drop_cnt_o    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_trace_arbiter.sv
// ============================================================================
// Module  : tb_rvfi_trace_arbiter
// Purpose : Directed self-checking bench for rvfi_trace_arbiter with
//           DEPTH=4, NR_COMMIT_PORTS=2 and a queue of expected trace records.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvfi_trace_arbiter;
   import rvfi_pkg::*;

   localparam int c_NP = 2;
   localparam int c_D  = 4;

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   rvfi_instr_t [c_NP-1:0]   rvfi_i;
   logic                     trace_valid_o;
   logic                     trace_ready_i;
   rvfi_trace_rec_t          trace_o;
   logic [$clog2(c_D):0]     level_o;
   logic                     overflow_o;
   logic [31:0]              drop_cnt_o;

   rvfi_trace_arbiter #(
      .NR_COMMIT_PORTS (c_NP),
      .DEPTH           (c_D)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rvfi_i        (rvfi_i),
      .trace_valid_o (trace_valid_o),
      .trace_ready_i (trace_ready_i),
      .trace_o       (trace_o),
      .level_o       (level_o),
      .overflow_o    (overflow_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int                n_cmp = 0;
   int                n_err = 0;
   rvfi_trace_rec_t   q[$];
   int                m_level;
   logic [31:0]       m_seq;
   int                m_drop;
   logic              m_ovf;
   logic [31:0]       tag = 32'h100;

   function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [31:0] id);
      rvfi_instr_t r;
      r          = '0;
      r.valid    = v;
      r.trap     = t;
      r.insn     = id;
      r.order    = 64'(id);
      r.pc_rdata = id << 2;
      r.pc_wdata = (id << 2) + 32'd4;
      r.rd_addr  = id[4:0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic chk_rec(input string name, input rvfi_trace_rec_t obs, input rvfi_trace_rec_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed seq=%0h port=%0h insn=%0h trap=%0b expected seq=%0h port=%0h insn=%0h trap=%0b",
                name, obs.seq, obs.port, obs.instr.insn, obs.instr.trap,
                exp.seq, exp.port, exp.instr.insn, exp.instr.trap);
      end
   endtask

   // Called at a negedge: checks the outputs produced by the previous edge,
   // drives this cycle's inputs, updates the expectation, then advances.
   task automatic step(input logic rdy, input logic v0, input logic t0,
                       input logic v1, input logic t1);
      logic       pop;
      logic [1:0] el;
      int         n;
      int         fr;
      chk("level", 64'(level_o), 64'(m_level));
      chk("valid", 64'(trace_valid_o), 64'(m_level != 0));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      if (m_level != 0 && q.size() != 0) begin
         chk_rec("head", trace_o, q[0]);
      end
      rvfi_i[0]     = mk(v0, t0, tag);
      rvfi_i[1]     = mk(v1, t1, tag + 32'd1);
      tag           = tag + 32'd2;
      trace_ready_i = rdy;
      pop = (m_level != 0) && rdy;
      if (pop) void'(q.pop_front());
      el = {v1 | t1, v0 | t0};
      n  = int'(el[0]) + int'(el[1]);
      fr = c_D - m_level + int'(pop);
      if (n <= fr) begin
         for (int p = 0; p < c_NP; p++) begin
            if (el[p]) begin
               q.push_back('{instr: rvfi_i[p], seq: m_seq, port: 8'(p)});
               m_seq = m_seq + 32'd1;
            end
         end
         m_level = m_level + n;
      end else begin
         m_drop = m_drop + n;
         m_ovf  = 1'b1;
      end
      if (pop) m_level = m_level - 1;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Reset with live records on both ports; they must be discarded.
   task automatic do_reset();
      rst_i         = 1'b1;
      rvfi_i[0]     = mk(1'b1, 1'b0, 32'hdead);
      rvfi_i[1]     = mk(1'b1, 1'b0, 32'hbeef);
      trace_ready_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i   = 1'b0;
      rvfi_i  = '0;
      q.delete();
      m_level = 0;
      m_seq   = '0;
      m_drop  = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 16; i++) begin
         if (m_level == 0) break;
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("drain_level", 64'(level_o), 64'd0);
      chk("drain_valid", 64'(trace_valid_o), 64'd0);
   endtask

   initial begin
      rst_i         = 1'b1;
      rvfi_i        = '0;
      trace_ready_i = 1'b0;

      // Reset state
      do_reset();
      chk("rst_valid", 64'(trace_valid_o), 64'd0);
      chk("rst_level", 64'(level_o), 64'd0);
      chk("rst_drop", 64'(drop_cnt_o), 64'd0);
      chk("rst_ovf", 64'(overflow_o), 64'd0);

      // Single record: one-cycle latency, then empty again
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("single_valid", 64'(trace_valid_o), 64'd1);
      chk("single_seq", 64'(trace_o.seq), 64'd0);
      chk("single_port", 64'(trace_o.port), 64'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("single_level_after", 64'(level_o), 64'd0);

      // Dual commit in one cycle
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      drain();

      // Port 1 only, then trap-only on port 0
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("p1_port", 64'(trace_o.port), 64'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("trap_flag", 64'(trace_o.instr.trap), 64'd1);
      chk("trap_port", 64'(trace_o.port), 64'd0);
      chk("trap_seq", 64'(trace_o.seq), 64'd1);
      drain();

      // Overflow: 3 buffered, then a 2-record cycle is dropped whole
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("ovf_level", 64'(level_o), 64'd3);
      chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
      chk("ovf_flag", 64'(overflow_o), 64'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ovf_level_full", 64'(level_o), 64'd4);

      // Full with simultaneous push and pop; pointers wrap
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("full_pushpop_level", 64'(level_o), 64'd4);
      chk("full_pushpop_drop", 64'(drop_cnt_o), 64'd2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // Reset mid-stream at level 3 with 5 drops
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_level", 64'(level_o), 64'd3);
      chk("mid_drop", 64'(drop_cnt_o), 64'd5);
      do_reset();
      chk("mid_rst_valid", 64'(trace_valid_o), 64'd0);
      chk("mid_rst_level", 64'(level_o), 64'd0);
      chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
      chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_seq", 64'(trace_o.seq), 64'd0);
      drain();

      // Mixed traffic with random back-pressure
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rvfi_trace_arbiter.md
# rvfi_trace_arbiter

Serializes the per-cycle RVFI commit records from all commit ports into one ordered, back-pressurable trace stream. It sits between the core's `rvfi_o` bundle and a single-port trace consumer: a file tracer, a DPI checker or a trace-encoder.

- Commit ports cannot be stalled, so the block buffers records in a FIFO.
- Each record gets a global sequence number.
- When the buffer cannot take a whole cycle's records, it drops them and counts the loss.

## Interface
Parameters:
- `NR_COMMIT_PORTS`, default 2: number of RVFI commit ports. Port 0 is the oldest within a cycle.
- `DEPTH`, default 8: FIFO entries. Must be a power of two and at least `NR_COMMIT_PORTS`.

Ports:
- `clk_i`, input, 1: clock. One clock domain; reset is synchronous and active-high.
- `rst_i`, input, 1: synchronous active-high reset.
- `rvfi_i`, input, `rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]`: commit records.
- `trace_valid_o`, output, 1: the head record is available.
- `trace_ready_i`, input, 1: the consumer accepts the head record.
- `trace_o`, output, `rvfi_pkg::rvfi_trace_rec_t`: head record, made of `{instr, seq, port}`.
- `level_o`, output, `$clog2(DEPTH)+1`: current FIFO occupancy.
- `overflow_o`, output, 1: sticky; set on the first dropped cycle.
- `drop_cnt_o`, output, 32: total dropped records. Saturates at `32'hFFFF_FFFF`.

## Operation
- **Eligible record:** port `p` is eligible when `rvfi_i[p].valid || rvfi_i[p].trap`.
- **Packing:**
  - Eligible records are compacted in ascending port order; invalid ports are skipped.
  - `n` = number of eligible records, 0..`NR_COMMIT_PORTS`.
  - The `k`-th packed record gets `seq = seq_q + k` and `port = p`.
- **Pop:** `pop = trace_valid_o && trace_ready_i`.
- **Free space:** `free = DEPTH - level_q + pop`, so a same-cycle pop frees a slot for the push.
- **Accept** (`n <= free`):
  - Write all `n` records at `wr_ptr`, `wr_ptr+1`, … (modulo `DEPTH`).
  - `wr_ptr += n`, `seq_q += n`.
- **Reject** (`n > free`):
  - The whole cycle is dropped. There are no partial writes, so port order is never split.
  - `drop_cnt += n` (saturating), `overflow_o <= 1`.
  - `seq_q` does not advance.
- **Level update:** `level_q <= level_q + (accepted ? n : 0) - pop`.
- **Wrap-around:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are distinguished by `level_q`, not by the pointers.
- **Sequence counter:** `seq` is 32 bits and wraps from `FFFF_FFFF` to 0 without a flag.
- **Head output:**
  - `trace_valid_o = (level_q != 0)`.
  - `trace_o` is the entry at `rd_ptr`.
  - `trace_o` must be held stable while `trace_valid_o && !trace_ready_i`.
- **Reset (`rst_i` high at a clock edge):**
  - Pointers, `level_q`, `seq_q`, `drop_cnt_o` and `overflow_o` go to 0.
  - `trace_valid_o` goes to 0.
  - FIFO contents are don't-care.
  - Records presented in the reset cycle are discarded and not counted.
  - A reset mid-stream discards buffered records silently.

## Timing
- Push-to-output latency is 1 cycle. A record arriving at edge N appears on `trace_o` after edge N if the FIFO was empty.
- There is no combinational path from `rvfi_i` to `trace_o` or `trace_valid_o`.
- `trace_ready_i` affects only state; it has no combinational path to outputs.
- Throughput: at most `NR_COMMIT_PORTS` pushes and 1 pop per cycle.
- All outputs are registered or decoded from registers.
- `overflow_o` and `drop_cnt_o` update on the edge after the rejected cycle.

## Structure
- In `rvfi_pkg`, add `rvfi_trace_rec_t` with fields:
  - `instr`, type `rvfi_instr_t`;
  - `seq`, `logic [31:0]`;
  - `port`, `logic [7:0]`.
- One sub-module, `rvfi_commit_packer`:
  - purely combinational;
  - computes `n` and the compacted record array with per-slot port index.
- The top level holds the FIFO storage array, pointers, level, sequence and drop counters, and the accept logic.

## Test plan
Scenarios use `DEPTH=4` and `NR_COMMIT_PORTS=2` unless stated.
1. **Single record:** after reset, `rvfi_i[0].valid=1` for one cycle with `trace_ready_i=1` → next cycle `trace_valid_o=1`, `seq=0`, `port=0`. The cycle after that, `level_o=0`.
2. **Dual commit:** ports 0 and 1 valid in the same cycle, ready held → two consecutive outputs: `(seq 0, port 0)` then `(seq 1, port 1)`.
3. **Port 1 only and trap only:** `rvfi_i[1].valid=1` in one cycle, then `rvfi_i[0].trap=1` with `valid=0` in the next → outputs are `(seq 0, port 1)` then `(seq 1, port 0)`, and `instr.trap=1` on the second.
4. **Overflow:**
   - Stimulus: hold `trace_ready_i=0`, push 3 records, then push 2 in one cycle.
   - Response: `level_o=3`, `drop_cnt_o=2`, `overflow_o=1`.
   - A subsequent single push gets `seq=3` and `level_o=4`.
5. **Full with simultaneous push/pop:** at `level_o=4`, `trace_ready_i=1`, push 1 → accepted, `level_o` stays 4, `drop_cnt_o` unchanged, and read and write pointers both wrap.
6. **Reset mid-stream:** at `level_o=3` with `drop_cnt_o=5`, assert `rst_i` for one cycle while ports are valid → `trace_valid_o=0`, `level_o=0`, `drop_cnt_o=0`, `overflow_o=0`. The next push gets `seq=0`.
